// File: rtl/ghost_rand_gen.sv
// ghost_rand_gen: per-channel 16-bit Fibonacci LFSRs with registered on-request sampling.
// Define GHOST_RAND_RANGE_LIMIT_EN to fold each sample below LIMIT with one subtraction.
module ghost_rand_gen #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 5,
  parameter int LIMIT    = 640
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       req,
  input  logic                      seed_load,
  input  logic [15:0]               seed_data,
  output logic [CHANNELS*WIDTH-1:0] rand_out,
  output logic [CHANNELS-1:0]       rand_valid
);
  localparam logic [15:0] SEED = 16'hACE1;
  if (WIDTH < 4 || WIDTH > 16 || CHANNELS < 1 || CHANNELS > 8 ||
      LIMIT <= (1 << (WIDTH - 1)) || LIMIT > (1 << WIDTH)) begin : g_bad
    $error("ghost_rand_gen: illegal parameters");
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [15:0] MIX = 16'(c * 32'h1357);
    // A zero state would lock the LFSR, so any zero seed falls back to SEED.
    localparam logic [15:0] DEF = ((SEED ^ MIX) == 16'h0000) ? SEED : (SEED ^ MIX);
    logic [15:0]      r_state;
    logic [WIDTH-1:0] r_sample;
    logic             r_valid;
    logic [15:0]      w_mixed;
    logic [15:0]      w_load;
    logic [15:0]      w_next;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_red;
    assign w_mixed = seed_data ^ MIX;
    assign w_load  = (w_mixed == 16'h0000) ? SEED : w_mixed;
    assign w_next  = {r_state[14:0], r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10]};
    assign w_raw   = r_state[WIDTH-1:0];
`ifdef GHOST_RAND_RANGE_LIMIT_EN
    localparam logic [WIDTH:0] LIM = (WIDTH + 1)'(LIMIT);
    logic [WIDTH:0] w_diff;
    // Borrow out of the subtraction means the raw value is already below LIMIT.
    assign w_diff = {1'b0, w_raw} - LIM;
    assign w_red  = w_diff[WIDTH] ? w_raw : w_diff[WIDTH-1:0];
`else
    assign w_red  = w_raw;
`endif
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state  <= DEF;
        r_sample <= '0;
        r_valid  <= 1'b0;
      end else begin
        r_state <= seed_load ? w_load : (en ? w_next : r_state);
        r_valid <= req[c];
        if (req[c]) r_sample <= w_red;
      end
    end
    assign rand_out[c*WIDTH +: WIDTH] = r_sample;
    assign rand_valid[c]              = r_valid;
  end
endmodule

// File: tb/tb_ghost_rand_gen.sv
// tb_ghost_rand_gen: directed vector table, LFSR period run and randomized run against a reference model.
module tb_ghost_rand_gen;
  localparam int W   = 10;
  localparam int C   = 5;
  localparam int LIM = 640;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic [C-1:0]   req = '0;
  logic           seed_load = 1'b0;
  logic [15:0]    seed_data = '0;
  logic [C*W-1:0] rand_out;
  logic [C-1:0]   rand_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ghost_rand_gen #(.WIDTH(W), .CHANNELS(C), .LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .seed_load(seed_load),
    .seed_data(seed_data), .rand_out(rand_out), .rand_valid(rand_valid)
  );

  logic [15:0]  ms [C];
  logic [W-1:0] mo [C];
  logic [C-1:0] mv;

  function automatic logic [15:0] nz(input logic [15:0] x);
    return (x == 16'h0000) ? 16'hACE1 : x;
  endfunction

  function automatic logic [15:0] mix(input int i);
    return 16'(i * 32'h1357);
  endfunction

  function automatic logic [15:0] lfsr(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [W-1:0] red(input logic [W-1:0] x);
`ifdef GHOST_RAND_RANGE_LIMIT_EN
    return (int'(x) >= LIM) ? W'(int'(x) - LIM) : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic [C-1:0] q,
                     input logic l, input logic [15:0] d);
    rst = r; en = e; req = q; seed_load = l; seed_data = d;
    @(posedge clk);
    if (r) begin
      mv = '0;
      for (int i = 0; i < C; i++) begin
        ms[i] = nz(16'hACE1 ^ mix(i));
        mo[i] = '0;
      end
    end else begin
      mv = q;
      for (int i = 0; i < C; i++) begin
        if (q[i]) mo[i] = red(ms[i][W-1:0]);
        ms[i] = l ? nz(d ^ mix(i)) : (e ? lfsr(ms[i]) : ms[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"}, 64'(rand_valid), 64'(mv));
    for (int i = 0; i < C; i++)
      chk($sformatf("%s slice%0d", tag, i), 64'(rand_out[i*W +: W]), 64'(mo[i]));
  endtask

  typedef struct {
    logic         r;
    logic         e;
    logic [C-1:0] q;
    logic         l;
    logic [15:0]  d;
    logic [C-1:0] ev;
    int           ch;
    logic [W-1:0] eraw;
  } vec_t;

  vec_t tv[14];

  initial begin
    tv[0]  = '{1'b1, 1'b0, 5'b00000, 1'b0, 16'h0000, 5'b00000, 0, 10'd0};
    tv[1]  = '{1'b0, 1'b1, 5'b00000, 1'b0, 16'h0000, 5'b00000, 0, 10'd0};
    tv[2]  = '{1'b0, 1'b0, 5'b00001, 1'b0, 16'h0000, 5'b00001, 0, 10'd451};
    tv[3]  = '{1'b1, 1'b0, 5'b00000, 1'b0, 16'h0000, 5'b00000, 0, 10'd0};
    tv[4]  = '{1'b0, 1'b0, 5'b11111, 1'b0, 16'h0000, 5'b11111, 0, 10'd225};
    tv[5]  = '{1'b0, 1'b0, 5'b11111, 1'b0, 16'h0000, 5'b11111, 4, 10'd445};
    tv[6]  = '{1'b0, 1'b0, 5'b11111, 1'b0, 16'h0000, 5'b11111, 3, 10'h2E4};
    tv[7]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 16'h0000, 5'b00000, 0, 10'd225};
    tv[8]  = '{1'b0, 1'b1, 5'b00000, 1'b0, 16'h0000, 5'b00000, 1, 10'h3B6};
    tv[9]  = '{1'b0, 1'b0, 5'b00010, 1'b1, 16'hACE1, 5'b00010, 1, 10'h36C};
    tv[10] = '{1'b0, 1'b0, 5'b00010, 1'b0, 16'h0000, 5'b00010, 1, 10'h3B6};
    tv[11] = '{1'b0, 1'b0, 5'b00000, 1'b1, 16'h0000, 5'b00000, 1, 10'h3B6};
    tv[12] = '{1'b0, 1'b0, 5'b00001, 1'b0, 16'h0000, 5'b00001, 0, 10'd225};
    tv[13] = '{1'b1, 1'b0, 5'b00100, 1'b0, 16'h0000, 5'b00000, 2, 10'd0};
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      cyc(tv[k].r, tv[k].e, tv[k].q, tv[k].l, tv[k].d);
      chk($sformatf("vec%0d valid", k), 64'(rand_valid), 64'(tv[k].ev));
      chk($sformatf("vec%0d slice%0d", k, tv[k].ch), 64'(rand_out[tv[k].ch*W +: W]),
          64'(red(tv[k].eraw)));
    end
    chk("rst all outputs zero", 64'(rand_out), 64'd0);
    cyc(1'b0, 1'b0, 5'b11111, 1'b0, 16'h0000);
    check_model("post-rst defaults");
    chk("post-rst slice0", 64'(rand_out[W-1:0]), 64'd225);
    // zero seed becomes ACE1; one full period of steps must bring channel 0 back to it
    cyc(1'b0, 1'b0, 5'b00000, 1'b1, 16'h0000);
    cyc(1'b0, 1'b1, 5'b00001, 1'b0, 16'h0000);
    chk("zero-load slice0", 64'(rand_out[W-1:0]), 64'd225);
    repeat (65534) cyc(1'b0, 1'b1, 5'b00000, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 5'b00001, 1'b0, 16'h0000);
    chk("period slice0", 64'(rand_out[W-1:0]), 64'd225);
    check_model("period");
    cyc(1'b1, 1'b0, 5'b00000, 1'b0, 16'h0000);
    for (int k = 0; k < 3000; k++) begin
      logic         r, e, l;
      logic [C-1:0] q;
      logic [15:0]  d;
      r = ($urandom_range(0, 199) == 0);
      e = 1'($urandom_range(0, 1));
      q = C'($urandom);
      l = ($urandom_range(0, 15) == 0);
      d = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      cyc(r, e, q, l, d);
      check_model("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
